// File: rtl/exec_sched.sv
// exec_sched: round-robin dispatcher for the shared 8-bit execute unit.
// Picks one ready reservation-station entry, holds its operands for the
// op latency, then presents the result on the CDB until the ROB takes it.
module exec_sched #(
  parameter int unsigned RS_N    = 4,
  parameter int unsigned LAT_ADD = 1,
  parameter int unsigned LAT_MUL = 3,
  parameter int unsigned LAT_DIV = 4
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              flush,
  input  logic [RS_N-1:0]   rs_req,
  input  logic [8*RS_N-1:0] rs_a,
  input  logic [8*RS_N-1:0] rs_b,
  input  logic [4*RS_N-1:0] rs_func,
  input  logic [3*RS_N-1:0] rs_rob,
  input  logic [4*RS_N-1:0] rs_rd,
  output logic [RS_N-1:0]   rs_grant,
  output logic [7:0]        ex_a,
  output logic [7:0]        ex_b,
  output logic [3:0]        ex_func,
  output logic              ex_busy,
  input  logic [7:0]        ex_result,
  output logic              cdb_valid,
  input  logic              cdb_ready,
  output logic [7:0]        cdb_data,
  output logic [2:0]        cdb_rob,
  output logic [3:0]        cdb_rd,
  output logic              cdb_err
);

  localparam int unsigned PW      = $clog2(RS_N);
  localparam int unsigned LAT_AM  = (LAT_ADD > LAT_MUL) ? LAT_ADD : LAT_MUL;
  localparam int unsigned LAT_MAX = (LAT_AM > LAT_DIV) ? LAT_AM : LAT_DIV;
  localparam int unsigned CW      = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;

  localparam logic [3:0] F_ADD = 4'h0;
  localparam logic [3:0] F_SUB = 4'h1;
  localparam logic [3:0] F_MUL = 4'h2;
  localparam logic [3:0] F_DIV = 4'h3;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] func;
    logic [2:0] rob;
    logic [3:0] rd;
  } rs_entry_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   rr_ptr, rr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      ex_a_d, ex_b_d, cdb_data_d;
  logic [3:0]      ex_func_d, cdb_rd_d;
  logic [2:0]      cdb_rob_d;
  logic            ex_busy_d, cdb_valid_d, cdb_err_d;

  rs_entry_t       entry [RS_N];
  rs_entry_t       sel;
  logic [PW-1:0]   cand, pick_idx;
  logic            pick_found, grant_c, sel_legal, div_zero;

  // Unpack the flat request buses into per-entry records
  for (genvar i = 0; i < int'(RS_N); i++) begin : g_unpack
    assign entry[i] = '{a:    rs_a[8*i +: 8],
                        b:    rs_b[8*i +: 8],
                        func: rs_func[4*i +: 4],
                        rob:  rs_rob[3*i +: 3],
                        rd:   rs_rd[4*i +: 4]};
  end

  // Round-robin search starting just after the last granted entry
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned k = 1; k <= RS_N; k++) begin
      cand = PW'((32'(rr_ptr) + k) % RS_N);
      if (!pick_found && rs_req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign grant_c   = (state_q == IDLE) && !rst && !flush && pick_found;
  assign rs_grant  = grant_c ? (RS_N'(1) << pick_idx) : '0;
  assign sel       = entry[pick_idx];
  assign sel_legal = (sel.func[3:2] == 2'b00);
  assign div_zero  = (ex_func == F_DIV) && (ex_b == 8'd0);

  // Remaining execute cycles after the first, by func code
  function automatic logic [CW-1:0] lat_m1(input logic [3:0] f);
    case (f)
      F_ADD, F_SUB: lat_m1 = CW'(LAT_ADD - 1);
      F_MUL:        lat_m1 = CW'(LAT_MUL - 1);
      default:      lat_m1 = CW'(LAT_DIV - 1);
    endcase
  endfunction

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_ptr;
    cnt_d       = cnt_q;
    ex_a_d      = ex_a;
    ex_b_d      = ex_b;
    ex_func_d   = ex_func;
    ex_busy_d   = ex_busy;
    cdb_valid_d = cdb_valid;
    cdb_data_d  = cdb_data;
    cdb_rob_d   = cdb_rob;
    cdb_rd_d    = cdb_rd;
    cdb_err_d   = cdb_err;
    case (state_q)
      IDLE: begin
        if (grant_c) begin
          ex_a_d    = sel.a;
          ex_b_d    = sel.b;
          ex_func_d = sel.func;
          cdb_rob_d = sel.rob;
          cdb_rd_d  = sel.rd;
          rr_d      = pick_idx;
          if (sel_legal) begin
            cnt_d     = lat_m1(sel.func);
            ex_busy_d = 1'b1;
            state_d   = EXEC;
          end else begin
            // Illegal op bypasses the execute unit entirely
            cdb_valid_d = 1'b1;
            cdb_data_d  = 8'h00;
            cdb_err_d   = 1'b1;
            state_d     = WB;
          end
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          cdb_valid_d = 1'b1;
          cdb_data_d  = div_zero ? 8'hFF : ex_result;
          cdb_err_d   = div_zero;
          ex_busy_d   = 1'b0;
          state_d     = WB;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      WB: begin
        if (cdb_valid && cdb_ready) begin
          cdb_valid_d = 1'b0;
          cdb_err_d   = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Flush kills whatever is in flight, including a same-cycle transfer
    if (flush) begin
      state_d     = IDLE;
      cdb_valid_d = 1'b0;
      cdb_err_d   = 1'b0;
      ex_busy_d   = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr    <= PW'(RS_N - 1);
      cnt_q     <= '0;
      ex_a      <= '0;
      ex_b      <= '0;
      ex_func   <= '0;
      ex_busy   <= 1'b0;
      cdb_valid <= 1'b0;
      cdb_data  <= '0;
      cdb_rob   <= '0;
      cdb_rd    <= '0;
      cdb_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_ptr    <= rr_d;
      cnt_q     <= cnt_d;
      ex_a      <= ex_a_d;
      ex_b      <= ex_b_d;
      ex_func   <= ex_func_d;
      ex_busy   <= ex_busy_d;
      cdb_valid <= cdb_valid_d;
      cdb_data  <= cdb_data_d;
      cdb_rob   <= cdb_rob_d;
      cdb_rd    <= cdb_rd_d;
      cdb_err   <= cdb_err_d;
    end
  end

endmodule

// File: tb/tb_exec_sched.sv
// Scoreboard bench for exec_sched with a behavioural execute unit.
module tb_exec_sched;

  localparam int unsigned RS_N    = 4;
  localparam int unsigned LAT_ADD = 1;
  localparam int unsigned LAT_MUL = 3;
  localparam int unsigned LAT_DIV = 4;

  logic              clk1 = 1'b0;
  logic              rst, flush, cdb_ready;
  logic [RS_N-1:0]   rs_req, rs_grant;
  logic [8*RS_N-1:0] rs_a, rs_b;
  logic [4*RS_N-1:0] rs_func, rs_rd;
  logic [3*RS_N-1:0] rs_rob;
  logic [7:0]        ex_a, ex_b, ex_result, cdb_data;
  logic [3:0]        ex_func, cdb_rd;
  logic [2:0]        cdb_rob;
  logic              ex_busy, cdb_valid, cdb_err;

  typedef struct {
    logic [7:0]  data;
    logic [2:0]  rob;
    logic [3:0]  rd;
    logic        err;
    int unsigned due;
    int unsigned lat;
  } exp_t;

  exp_t        sb[$];
  int unsigned gq[$];
  int unsigned n_cmp = 0, n_err = 0;
  int unsigned cyc = 0, grant_cnt = 0, busy_cnt = 0;
  int unsigned rr_m = RS_N - 1;
  bit          busy_m = 1'b0, valid_seen = 1'b0;

  exec_sched #(.RS_N(RS_N), .LAT_ADD(LAT_ADD), .LAT_MUL(LAT_MUL), .LAT_DIV(LAT_DIV)) dut (
    .clk1(clk1), .rst(rst), .flush(flush),
    .rs_req(rs_req), .rs_a(rs_a), .rs_b(rs_b), .rs_func(rs_func),
    .rs_rob(rs_rob), .rs_rd(rs_rd), .rs_grant(rs_grant),
    .ex_a(ex_a), .ex_b(ex_b), .ex_func(ex_func), .ex_busy(ex_busy),
    .ex_result(ex_result), .cdb_valid(cdb_valid), .cdb_ready(cdb_ready),
    .cdb_data(cdb_data), .cdb_rob(cdb_rob), .cdb_rd(cdb_rd), .cdb_err(cdb_err)
  );

  always #5 clk1 = ~clk1;

  always @(posedge clk1) cyc <= cyc + 1;

  // Behavioural execute unit; divide by zero returns junk the DUT must ignore
  function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f);
    case (f)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return 8'(16'(a) * 16'(b));
      4'd3:    return (b == 8'd0) ? 8'h5A : a / b;
      default: return 8'hC3;
    endcase
  endfunction

  assign ex_result = alu(ex_a, ex_b, ex_func);

  function automatic exp_t expect_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] f,
                                     input logic [2:0] rob, input logic [3:0] rd, input int unsigned now);
    exp_t e;
    e.rob = rob;
    e.rd  = rd;
    if (f > 4'd3) begin
      e.data = 8'h00; e.err = 1'b1; e.lat = 0;
    end else begin
      e.lat  = (f == 4'd2) ? LAT_MUL : (f == 4'd3) ? LAT_DIV : LAT_ADD;
      e.err  = (f == 4'd3) && (b == 8'd0);
      e.data = e.err ? 8'hFF : alu(a, b, f);
    end
    e.due = now + e.lat + 1;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Reference arbiter and CDB scoreboard, sampled mid-cycle
  always @(negedge clk1) begin
    logic [RS_N-1:0] exp_g, tmp;
    int unsigned     pick, idx;
    exp_t            e;
    if (rst) begin
      rr_m = RS_N - 1; busy_m = 1'b0; valid_seen = 1'b0; busy_cnt = 0;
      sb.delete();
    end else begin
      exp_g = '0;
      pick  = 0;
      if (!busy_m && !flush && rs_req != '0) begin
        for (int unsigned k = 1; k <= RS_N; k++) begin
          idx = (rr_m + k) % RS_N;
          tmp = rs_req >> idx;
          if (exp_g == '0 && tmp[0]) begin
            exp_g = RS_N'(1) << idx;
            pick  = idx;
          end
        end
      end
      if (rs_req != '0 || rs_grant != '0) check("grant", 32'(rs_grant), 32'(exp_g));
      if (cdb_valid && !busy_m) check("spurious_valid", 32'(cdb_valid), 32'd0);
      if (flush) begin
        if (sb.size() > 0) void'(sb.pop_front());
        busy_m = 1'b0;
      end else if (exp_g != '0) begin
        sb.push_back(expect_op(8'(rs_a >> (8*pick)), 8'(rs_b >> (8*pick)), 4'(rs_func >> (4*pick)),
                               3'(rs_rob >> (3*pick)), 4'(rs_rd >> (4*pick)), cyc));
        gq.push_back(pick);
        grant_cnt++;
        rr_m = pick; busy_m = 1'b1; busy_cnt = 0; valid_seen = 1'b0;
      end else if (busy_m) begin
        if (ex_busy) busy_cnt++;
        if (cdb_valid && sb.size() > 0) begin
          e = sb[0];
          if (!valid_seen) begin
            check("latency", cyc, e.due);
            check("busy_cycles", busy_cnt, e.lat);
            valid_seen = 1'b1;
          end
          check("cdb_data", 32'(cdb_data), 32'(e.data));
          check("cdb_rob", 32'(cdb_rob), 32'(e.rob));
          check("cdb_rd", 32'(cdb_rd), 32'(e.rd));
          check("cdb_err", 32'(cdb_err), 32'(e.err));
          if (cdb_ready) begin
            void'(sb.pop_front());
            busy_m = 1'b0;
          end
        end
      end
    end
  end

  task automatic set_entry(input int unsigned i, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] f, input logic [2:0] rob, input logic [3:0] rd);
    rs_a[8*i +: 8]    = a;
    rs_b[8*i +: 8]    = b;
    rs_func[4*i +: 4] = f;
    rs_rob[3*i +: 3]  = rob;
    rs_rd[4*i +: 4]   = rd;
  endtask

  task automatic wait_grant(input int unsigned budget);
    for (int unsigned i = 0; i < budget; i++) begin
      @(negedge clk1);
      if (rs_grant != '0) return;
    end
    check("grant_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_valid(input int unsigned budget);
    for (int unsigned i = 0; i < budget; i++) begin
      @(negedge clk1);
      if (cdb_valid) return;
    end
    check("valid_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_idle(input int unsigned budget);
    for (int unsigned i = 0; i < budget; i++) begin
      @(negedge clk1);
      if (!busy_m && sb.size() == 0) return;
    end
    check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic issue(input logic [RS_N-1:0] mask);
    @(posedge clk1); #1 rs_req = mask;
    wait_grant(20);
    @(posedge clk1); #1 rs_req = '0;
  endtask

  task automatic do_reset();
    @(posedge clk1); #1 rst = 1'b1;
    repeat (2) @(posedge clk1);
    #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned base;
    int unsigned ord [5] = '{0, 1, 2, 3, 0};
    rst = 1'b1; flush = 1'b0; cdb_ready = 1'b1; rs_req = '0;
    rs_a = '0; rs_b = '0; rs_func = '0; rs_rob = '0; rs_rd = '0;

    // Reset state
    repeat (3) @(posedge clk1);
    @(negedge clk1);
    check("rst_grant", 32'(rs_grant), 32'd0);
    check("rst_ex_busy", 32'(ex_busy), 32'd0);
    check("rst_cdb_valid", 32'(cdb_valid), 32'd0);
    check("rst_cdb_err", 32'(cdb_err), 32'd0);
    check("rst_cdb_data", 32'(cdb_data), 32'd0);
    check("rst_ex_a", 32'(ex_a), 32'd0);
    check("rst_ex_func", 32'(ex_func), 32'd0);
    @(posedge clk1); #1 rst = 1'b0;

    // Single add from entry 0
    set_entry(0, 8'd5, 8'd3, 4'h0, 3'd2, 4'd4);
    issue(4'b0001);
    wait_idle(20);

    // Continuous requests from all entries after a fresh reset
    do_reset();
    set_entry(0, 8'd10, 8'd20, 4'h0, 3'd0, 4'd1);
    set_entry(1, 8'd50, 8'd8, 4'h1, 3'd1, 4'd2);
    set_entry(2, 8'd12, 8'd12, 4'h2, 3'd2, 4'd3);
    set_entry(3, 8'd100, 8'd7, 4'h3, 3'd3, 4'd5);
    gq.delete();
    base = grant_cnt;
    @(posedge clk1); #1 rs_req = 4'hF;
    for (int unsigned i = 0; i < 200 && grant_cnt < base + 5; i++) @(negedge clk1);
    @(posedge clk1); #1 rs_req = '0;
    wait_idle(40);
    check("order_count", 32'(gq.size()), 32'd5);
    for (int unsigned i = 0; i < 5 && i < gq.size(); i++) check("grant_order", gq[i], ord[i]);

    // Divide by zero, then illegal func
    set_entry(1, 8'd9, 8'd0, 4'h3, 3'd5, 4'd6);
    issue(4'b0010);
    wait_idle(30);
    set_entry(2, 8'd1, 8'd2, 4'h7, 3'd6, 4'd7);
    issue(4'b0100);
    wait_idle(20);

    // Mul with back-pressure while entry 0 keeps requesting
    set_entry(3, 8'd6, 8'd7, 4'h2, 3'd7, 4'd8);
    set_entry(0, 8'd1, 8'd2, 4'h0, 3'd1, 4'd1);
    cdb_ready = 1'b0;
    @(posedge clk1); #1 rs_req = 4'b1001;
    wait_grant(20);
    wait_valid(20);
    repeat (5) @(negedge clk1);
    check("hold_data", 32'(cdb_data), 32'd42);
    @(posedge clk1); #1 cdb_ready = 1'b1;
    wait_grant(20);
    check("grant_after_hold", 32'(rs_grant), 32'b0001);
    @(posedge clk1); #1 rs_req = '0;
    wait_idle(20);

    // Flush on the second execute cycle of a mul
    set_entry(1, 8'd6, 8'd7, 4'h2, 3'd3, 4'd9);
    set_entry(2, 8'd1, 8'd1, 4'h0, 3'd4, 4'd10);
    @(posedge clk1); #1 rs_req = 4'b0110;
    wait_grant(20);
    check("flush_first_grant", 32'(rs_grant), 32'b0010);
    @(posedge clk1); #1;
    @(posedge clk1); #1 flush = 1'b1;
    @(negedge clk1);
    check("flush_cycle_grant", 32'(rs_grant), 32'd0);
    @(posedge clk1); #1 flush = 1'b0;
    @(negedge clk1);
    check("post_flush_valid", 32'(cdb_valid), 32'd0);
    check("post_flush_busy", 32'(ex_busy), 32'd0);
    check("post_flush_grant", 32'(rs_grant), 32'b0100);
    @(posedge clk1); #1 rs_req = '0;
    wait_idle(20);

    // Reset together with flush in the middle of a div
    set_entry(3, 8'd100, 8'd5, 4'h3, 3'd1, 4'd2);
    issue(4'b1000);
    #0 rst = 1'b1; flush = 1'b1;
    @(posedge clk1); #1 rst = 1'b0; flush = 1'b0; rs_req = 4'hF;
    @(negedge clk1);
    check("rst_mid_ex_busy", 32'(ex_busy), 32'd0);
    check("rst_mid_cdb_valid", 32'(cdb_valid), 32'd0);
    check("rst_mid_ex_a", 32'(ex_a), 32'd0);
    check("rst_mid_ex_b", 32'(ex_b), 32'd0);
    check("rst_mid_ex_func", 32'(ex_func), 32'd0);
    check("rst_mid_first_grant", 32'(rs_grant), 32'b0001);
    @(posedge clk1); #1 rs_req = '0;
    wait_idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/exec_sched.md
Name: exec_sched

Overview:
- Scheduler/controller for the shared 8-bit execute unit in the Tomasulo core.
- Arbitrates round-robin among RS_N reservation-station entries whose operands are ready, and dispatches one operation at a time to the execute unit.
- Holds operands stable for the op-dependent latency, captures the result, and presents it on the common data bus (CDB) with a valid/ready handshake toward the ROB.

Parameters:
- RS_N, 4, number of reservation-station requesters (2..8).
- LAT_ADD, 1, execute cycles for add/sub (>=1).
- LAT_MUL, 3, execute cycles for mul (>=1).
- LAT_DIV, 4, execute cycles for div (>=1).

Ports:
- clk1  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- flush  in  1  synchronous kill of in-flight op (mispredict/exception).
- rs_req  in  RS_N  entry i has both operands ready.
- rs_a  in  8*RS_N  operand A of entry i, bits [8i+7:8i].
- rs_b  in  8*RS_N  operand B of entry i.
- rs_func  in  4*RS_N  func code of entry i.
- rs_rob  in  3*RS_N  ROB index of entry i.
- rs_rd  in  4*RS_N  destination register of entry i.
- rs_grant  out  RS_N  one-hot; entry accepted this cycle (combinational).
- ex_a, ex_b  out  8  latched operands to execute unit.
- ex_func  out  4  latched func.
- ex_busy  out  1  execute unit occupied.
- ex_result  in  8  combinational result of execute unit for ex_a/ex_b/ex_func.
- cdb_valid  out  1  result available.
- cdb_ready  in  1  ROB accepts result.
- cdb_data  out  8  result.
- cdb_rob  out  3  ROB index of result.
- cdb_rd  out  4  destination register.
- cdb_err  out  1  illegal func or divide by zero.

Behaviour:
- Reset: synchronous, active-high, clk1 only; rst is the team's fixed reset. The design uses one clock and the reset is synchronous and active-high. Reset forces state IDLE, rr_ptr=RS_N-1, and clears all outputs (ex_*, cdb_*, ex_busy).
- States: IDLE, EXEC, WB.
- IDLE:
  - If any rs_req is set and rst/flush are low, grant the first requesting index scanning from rr_ptr+1 upward with wrap (modulo RS_N).
  - rs_grant is high for that cycle only.
  - At the edge: latch operands, func, rob and rd; set rr_ptr to the granted index; load cnt=LAT(func)-1; go to EXEC.
  - rs_grant=0 in every other state or cycle.
- Func map: 0000 add, 0001 sub -> LAT_ADD; 0010 mul -> LAT_MUL; 0011 div -> LAT_DIV.
- Illegal func (any other code): the entry is still granted but skips EXEC and goes directly to WB with cdb_data=0 and cdb_err=1.
- EXEC:
  - ex_busy=1; ex_a/ex_b/ex_func are held constant.
  - cnt decrements each cycle.
  - When cnt==0: capture ex_result into cdb_data, set cdb_valid=1, go to WB.
- Divide by zero (func 0011, b==0): the full LAT_DIV is still consumed; ex_result is ignored; cdb_data=8'hFF, cdb_err=1.
- Latency: with grant in cycle T, cdb_valid first rises in cycle T+LAT+1. For an illegal func, cdb_valid rises at T+1.
- WB:
  - cdb_valid, cdb_data, cdb_rob, cdb_rd and cdb_err are held stable until cdb_valid and cdb_ready are both high on an edge.
  - On that transfer: cdb_valid=0, cdb_err=0, go to IDLE. ex_busy=0 in WB.
  - No grant is made in WB; the next grant occurs earliest in the cycle after the transfer (one bubble).
- Flush: any state -> IDLE at the edge. Clears cdb_valid, cdb_err and ex_busy; no CDB transfer for the killed op; rs_grant is forced 0 in the flush cycle; rr_ptr is kept.
- Simultaneous rst and flush: rst wins.
- A flush in the same cycle as a WB transfer still clears the outputs; the ROB treats that transfer as discarded.
- rs_req dropping after grant has no effect; operands are already latched.

Test Plan:
- Reset then rs_req=0001, entry0 a=5 b=3 func=0000 rob=2 rd=4, cdb_ready=1 -> rs_grant=0001 in cycle T; cdb_valid=1 at T+2 with data=8, rob=2, rd=4, err=0; IDLE at T+3.
- All four entries requesting continuously, mixed funcs, cdb_ready=1 -> grants in order 0,1,2,3,0 after reset; each grant is 1 cycle after the previous transfer.
- Entry1 div a=9 b=0 -> ex_busy held 4 cycles; cdb_data=8'hFF, cdb_err=1. Entry2 func=0111 -> cdb_valid at T+1, data=0, err=1.
- Mul a=6 b=7 with cdb_ready=0 for 5 cycles after cdb_valid -> outputs stable (data=42); no further rs_grant; transfer and IDLE on the first ready cycle.
- Flush asserted on the 2nd EXEC cycle of a mul -> IDLE next edge; cdb_valid never rises for that op; the next requester (rr order preserved) is granted the cycle after.
- rst asserted mid-EXEC together with flush -> all outputs 0; rr_ptr back to RS_N-1, so entry0 is granted first after release.
